// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C target: register select codes, STATUS bit
// positions and FSM state encodings.
package i2c_slave_pkg;

    localparam logic [3:0] SEL_CTRL   = 4'd1;
    localparam logic [3:0] SEL_TXDATA = 4'd2;
    localparam logic [3:0] SEL_RXDATA = 4'd3;
    localparam logic [3:0] SEL_STATUS = 4'd4;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_OVERRUN  = 2;
    localparam int ST_BUSY     = 3;
    localparam int ST_DIR      = 4;
    localparam int ST_GCALL    = 5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ADDR      = 3'd1,
        S_ADDR_ACK  = 3'd2,
        S_RX        = 3'd3,
        S_RX_ACK    = 3'd4,
        S_TX        = 3'd5,
        S_TX_ACK    = 3'd6,
        S_WAIT_STOP = 3'd7
    } state_e;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an I2C pin plus a registered previous value,
// giving the synchronized level and single-cycle rise/fall pulses.
module i2c_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic in_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);
    logic s1_q, s2_q, prev_q;

    // Reset to 1 (idle bus level) so leaving reset never fakes an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            s1_q   <= in_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
        end
    end

    assign lvl_o  = s2_q;
    assign rise_o = s2_q & ~prev_q;
    assign fall_o = ~s2_q & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target peripheral with CTRL/TXDATA/RXDATA/STATUS registers.
// Optional I2C_SLAVE_GCALL_EN adds general-call (address 0x00 write) acceptance.
module i2c_slave
    import i2c_slave_pkg::*;
#(
    parameter logic [6:0] OWN_ADDR_RST = 7'h50
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    output logic [31:0] data_o,
    input  logic        scl,
    inout  wire         sda
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_sync_edge u_scl (.clk(clk), .rst(rst), .in_i(scl),
                         .lvl_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall));
    i2c_sync_edge u_sda (.clk(clk), .rst(rst), .in_i(sda),
                         .lvl_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall));

    state_e      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        sda_oe_q, sda_oe_d;
    logic        ack_q, ack_d;
    logic        dir_q, dir_d;
    logic        busy_q, busy_d;
    logic [6:0]  own_addr_q, own_addr_d;
    logic        enable_q, enable_d;
    logic [7:0]  txdata_q, txdata_d;
    logic [7:0]  rxdata_q, rxdata_d;
    logic        rx_valid_q, rx_valid_d;
    logic        tx_empty_q, tx_empty_d;
    logic        overrun_q, overrun_d;
    logic        gcall_q, gcall_d;

    logic [3:0]  sel;
    logic        start_cond, stop_cond, own_hit, gc_hit, tx_wr;
    logic [7:0]  rx_byte, tx_src;

    assign sel        = addr_i[19:16];
    assign start_cond = scl_lvl & sda_fall;
    assign stop_cond  = scl_lvl & sda_rise;
    assign rx_byte    = {shift_q[6:0], sda_lvl};
    assign own_hit    = (shift_q[6:0] == own_addr_q);
    assign tx_wr      = we_i && (sel == SEL_TXDATA);
    // A TXDATA write coinciding with a load is forwarded into the shifter.
    assign tx_src     = tx_wr ? data_i[7:0] : txdata_q;
`ifdef I2C_SLAVE_GCALL_EN
    assign gc_hit     = (shift_q[6:0] == 7'h00) && !sda_lvl;
`else
    assign gc_hit     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            sda_oe_q   <= 1'b0;
            ack_q      <= 1'b0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            own_addr_q <= OWN_ADDR_RST;
            enable_q   <= 1'b0;
            txdata_q   <= 8'h00;
            rxdata_q   <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_empty_q <= 1'b1;
            overrun_q  <= 1'b0;
            gcall_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sda_oe_q   <= sda_oe_d;
            ack_q      <= ack_d;
            dir_q      <= dir_d;
            busy_q     <= busy_d;
            own_addr_q <= own_addr_d;
            enable_q   <= enable_d;
            txdata_q   <= txdata_d;
            rxdata_q   <= rxdata_d;
            rx_valid_q <= rx_valid_d;
            tx_empty_q <= tx_empty_d;
            overrun_q  <= overrun_d;
            gcall_q    <= gcall_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sda_oe_d   = sda_oe_q;
        ack_d      = ack_q;
        dir_d      = dir_q;
        busy_d     = busy_q;
        own_addr_d = own_addr_q;
        enable_d   = enable_q;
        txdata_d   = txdata_q;
        rxdata_d   = rxdata_q;
        rx_valid_d = rx_valid_q;
        tx_empty_d = tx_empty_q;
        overrun_d  = overrun_q;
        gcall_d    = gcall_q;

        // Bus writes come first so that flag sets from the bus below win.
        if (we_i) begin
            case (sel)
                SEL_CTRL: begin
                    own_addr_d = data_i[6:0];
                    enable_d   = data_i[7];
                end
                SEL_TXDATA: begin
                    txdata_d   = data_i[7:0];
                    tx_empty_d = 1'b0;
                end
                SEL_STATUS: begin
                    if (data_i[ST_RX_VALID]) rx_valid_d = 1'b0;
                    if (data_i[ST_OVERRUN])  overrun_d  = 1'b0;
                    if (data_i[ST_GCALL])    gcall_d    = 1'b0;
                end
                default: ;
            endcase
        end

        if (!enable_q) begin
            state_d   = S_IDLE;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (start_cond) begin
            state_d   = S_ADDR;
            bit_cnt_d = 3'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_cond) begin
            state_d   = S_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (own_hit || gc_hit) begin
                            state_d = S_ADDR_ACK;
                            dir_d   = sda_lvl;
                            busy_d  = 1'b1;
                            ack_d   = 1'b1;
                            if (gc_hit) gcall_d = 1'b1;
                        end else begin
                            state_d = S_WAIT_STOP;
                            busy_d  = 1'b0;
                        end
                    end
                end
                // bit_cnt 0: waiting for the fall that opens the ACK slot; 1: the fall that closes it.
                S_ADDR_ACK, S_RX_ACK: if (scl_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        bit_cnt_d = 3'd1;
                        sda_oe_d  = ack_q;
                    end else begin
                        bit_cnt_d = 3'd0;
                        if (state_q == S_ADDR_ACK && dir_q) begin
                            shift_d    = tx_src;
                            sda_oe_d   = ~tx_src[7];
                            tx_empty_d = 1'b1;
                            state_d    = S_TX;
                        end else begin
                            sda_oe_d   = 1'b0;
                            state_d    = S_RX;
                        end
                    end
                end
                S_RX: if (scl_rise) begin
                    shift_d   = rx_byte;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_RX_ACK;
                        if (!rx_valid_q) begin
                            rxdata_d   = rx_byte;
                            rx_valid_d = 1'b1;
                            ack_d      = 1'b1;
                        end else begin
                            overrun_d  = 1'b1;
                            ack_d      = 1'b0;
                        end
                    end
                end
                S_TX: if (scl_fall) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_TX_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                // The reloaded MSB is only driven after scl falls, never while scl is high.
                S_TX_ACK: begin
                    if (bit_cnt_q == 3'd0) begin
                        if (scl_rise) begin
                            if (!sda_lvl) begin
                                shift_d    = tx_src;
                                tx_empty_d = 1'b1;
                                bit_cnt_d  = 3'd1;
                            end else begin
                                state_d    = S_WAIT_STOP;
                            end
                        end
                    end else if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        sda_oe_d  = ~shift_q[7];
                        state_d   = S_TX;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        data_o = 32'h0;
        case (sel)
            SEL_CTRL:   data_o = {24'h0, enable_q, own_addr_q};
            SEL_TXDATA: data_o = {24'h0, txdata_q};
            SEL_RXDATA: data_o = {24'h0, rxdata_q};
            SEL_STATUS: data_o = {26'h0, gcall_q, dir_q, busy_q, overrun_q, tx_empty_q, rx_valid_q};
            default:    data_o = 32'h0;
        endcase
    end

    assign sda = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: drives an I2C master model on scl/sda and
// checks bus responses and register contents against hand-computed values.
module tb_i2c_slave;
    import i2c_slave_pkg::*;

    localparam int Q = 50;   // quarter scl period in time units (5 clk cycles)

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] data_i = 32'h0;
    logic [31:0] addr_i = 32'h0;
    logic        we_i = 1'b0;
    logic [31:0] data_o;
    logic        scl = 1'b1;
    logic        m_low = 1'b0;
    wire         sda_w;

    int n_checks = 0;
    int n_errors = 0;

    pullup (sda_w);
    assign sda_w = m_low ? 1'b0 : 1'bz;

    i2c_slave dut (
        .clk(clk), .rst(rst), .data_i(data_i), .addr_i(addr_i), .we_i(we_i),
        .data_o(data_o), .scl(scl), .sda(sda_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic reg_write(input logic [3:0] sel, input logic [31:0] d);
        @(negedge clk);
        addr_i = {12'h0, sel, 16'h0};
        data_i = d;
        we_i   = 1'b1;
        @(negedge clk);
        we_i   = 1'b0;
        data_i = 32'h0;
    endtask

    task automatic expect_reg(input string tag, input logic [3:0] sel, input logic [31:0] exp);
        @(negedge clk);
        addr_i = {12'h0, sel, 16'h0};
        #1;
        check(tag, data_o, exp);
    endtask

    task automatic i2c_start();
        m_low = 1'b0; #(Q);
        scl   = 1'b1; #(Q);
        m_low = 1'b1; #(Q);
        scl   = 1'b0; #(Q);
    endtask

    task automatic i2c_stop();
        m_low = 1'b1; #(Q);
        scl   = 1'b1; #(Q);
        m_low = 1'b0; #(Q);
    endtask

    task automatic write_bit(input logic b);
        m_low = ~b; #(Q);
        scl   = 1'b1; #(2*Q);
        scl   = 1'b0; #(Q);
    endtask

    task automatic read_bit(output logic b);
        m_low = 1'b0; #(Q);
        scl   = 1'b1; #(Q);
        b     = sda_w; #(Q);
        scl   = 1'b0; #(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic acked);
        logic b;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(b);
        acked = (b == 1'b0);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            d[i] = b;
        end
        write_bit(~ack);
    endtask

    initial begin
        logic       ak;
        logic [7:0] rd;
        logic [7:0] a0;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        expect_reg("reset_status", SEL_STATUS, 32'h02);
        expect_reg("reset_ctrl",   SEL_CTRL,   32'h50);
        reg_write(SEL_CTRL, 32'hD0);
        expect_reg("ctrl_enable",  SEL_CTRL,   32'hD0);

        // Write 0x50+W then 0xA5
        i2c_start();
        write_byte(8'hA0, ak); check("wr_addr_ack", {31'h0, ak}, 32'h1);
        write_byte(8'hA5, ak); check("wr_data_ack", {31'h0, ak}, 32'h1);
        expect_reg("wr_status_busy", SEL_STATUS, 32'h0B);
        i2c_stop();
        expect_reg("wr_rxdata", SEL_RXDATA, 32'hA5);
        expect_reg("wr_status_idle", SEL_STATUS, 32'h03);

        // Overrun: second byte NACKed while rx_valid still set
        reg_write(SEL_STATUS, 32'h05);
        expect_reg("w1c_clear", SEL_STATUS, 32'h02);
        i2c_start();
        write_byte(8'hA0, ak); check("ov_addr_ack", {31'h0, ak}, 32'h1);
        write_byte(8'h11, ak); check("ov_b1_ack",   {31'h0, ak}, 32'h1);
        write_byte(8'h22, ak); check("ov_b2_nack",  {31'h0, ak}, 32'h0);
        i2c_stop();
        expect_reg("ov_rxdata", SEL_RXDATA, 32'h11);
        expect_reg("ov_status", SEL_STATUS, 32'h07);
        reg_write(SEL_STATUS, 32'h05);

        // Read one byte of 0x3C, then NACK
        reg_write(SEL_TXDATA, 32'h3C);
        expect_reg("tx_not_empty", SEL_STATUS, 32'h00);
        i2c_start();
        write_byte(8'hA1, ak); check("rd_addr_ack", {31'h0, ak}, 32'h1);
        read_byte(1'b0, rd);   check("rd_data", {24'h0, rd}, 32'h3C);
        expect_reg("rd_status_busy", SEL_STATUS, 32'h1A);
        i2c_stop();
        expect_reg("rd_status_idle", SEL_STATUS, 32'h12);

        // Non-matching address 0x51
        i2c_start();
        write_byte(8'hA2, ak); check("miss_nack", {31'h0, ak}, 32'h0);
        expect_reg("miss_not_busy", SEL_STATUS, 32'h12);
        i2c_stop();

        // Repeated START: write address, then read address
        i2c_start();
        write_byte(8'hA0, ak); check("rs_wr_ack", {31'h0, ak}, 32'h1);
        i2c_start();
        write_byte(8'hA1, ak); check("rs_rd_ack", {31'h0, ak}, 32'h1);
        read_byte(1'b0, rd);   check("rs_rd_data", {24'h0, rd}, 32'h3C);
        expect_reg("rs_status_dir", SEL_STATUS, 32'h1A);
        i2c_stop();

        // General call address
        a0 = 8'h00;
        i2c_start();
        write_byte(a0, ak);
`ifdef I2C_SLAVE_GCALL_EN
        check("gcall_ack", {31'h0, ak}, 32'h1);
        expect_reg("gcall_status", SEL_STATUS, 32'h2A);
`else
        check("gcall_nack", {31'h0, ak}, 32'h0);
        expect_reg("gcall_status", SEL_STATUS, 32'h12);
`endif
        i2c_stop();

        // Reset asserted while the address ACK is being driven
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(a0[i] | (i == 7) | (i == 5));
        m_low = 1'b0; #(Q);
        scl   = 1'b1; #(Q);
        check("ack_driven", {31'h0, sda_w}, 32'h0);
        rst = 1'b0;
        #1;
        check("rst_sda_released", {31'h0, sda_w}, 32'h1);
        addr_i = {12'h0, SEL_STATUS, 16'h0};
        #1;
        check("rst_status", data_o, 32'h02);
        addr_i = {12'h0, SEL_CTRL, 16'h0};
        #1;
        check("rst_ctrl", data_o, 32'h50);
        #(Q);
        scl = 1'b0;
        rst = 1'b1;
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
